// File: rtl/zeroriscy_fetch_req_ctrl.sv
// Instruction fetch request controller for the prefetch path.
// Issues single outstanding word fetches on the instruction memory port and
// pushes every returned word, tagged with its address, into the fetch FIFO.
// Branches clear the FIFO, redirect fetching and discard stale responses.
module zeroriscy_fetch_req_ctrl #(
  parameter logic [31:0] RESET_FETCH_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        busy_o,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_GNT     = 2'd1;
  localparam logic [1:0] WAIT_RVALID  = 2'd2;
  localparam logic [1:0] WAIT_ABORTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        issue;
  logic [31:0] branch_addr;
  logic [31:0] seq_addr;
  logic [31:0] next_addr;

  // Bit 0 of a branch target is meaningless for instruction addresses.
  assign branch_addr  = addr_i & 32'hFFFF_FFFE;
  assign seq_addr     = {fetch_addr_q[31:2], 2'b00} + 32'd4;
  assign issue        = (req_i && fifo_ready_i) || branch_i;

  assign busy_o       = (state_q != IDLE);
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = fetch_addr_q;
  assign fifo_rdata_o = instr_rdata_i;
  assign instr_addr_o = {next_addr[31:2], 2'b00};

  // Address presented to memory: a branch target wins, and a word arriving
  // in WAIT_RVALID advances to the sequential address so a back-to-back
  // request fetches the following word.
  always_comb begin
    next_addr = fetch_addr_q;
    if (branch_i) begin
      next_addr = branch_addr;
    end else if (state_q == WAIT_RVALID && instr_rvalid_i) begin
      next_addr = seq_addr;
    end
  end

  // Transaction state machine: request issue, response push and discard.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    instr_req_o  = 1'b0;
    fifo_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          instr_req_o  = 1'b1;
          fetch_addr_d = next_addr;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        fetch_addr_d = next_addr;
        if (instr_gnt_i) begin
          state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (branch_i) begin
          fetch_addr_d = branch_addr;
          if (instr_rvalid_i) begin
            instr_req_o = 1'b1;
            state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end else begin
            state_d = WAIT_ABORTED;
          end
        end else if (instr_rvalid_i) begin
          fifo_valid_o = 1'b1;
          fetch_addr_d = seq_addr;
          if (issue) begin
            instr_req_o = 1'b1;
            state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_ABORTED: begin
        if (instr_rvalid_i) begin
          instr_req_o  = 1'b1;
          fetch_addr_d = next_addr;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else if (branch_i) begin
          fetch_addr_d = branch_addr;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and fetch address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_FETCH_ADDR;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  // A response while waiting for a grant means the memory broke protocol.
  // In IDLE it can be a leftover from a transaction cut short by reset,
  // so it is silently ignored there.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(state_q == WAIT_GNT && instr_rvalid_i));

endmodule

// File: tb/tb_zeroriscy_fetch_req_ctrl.sv
// Self-checking bench for zeroriscy_fetch_req_ctrl: directed vector table,
// reset corner case, then randomized traffic against a scoreboard model.
module tb_zeroriscy_fetch_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        busy_o;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic        fifo_ready_i;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  int checks = 0;
  int errors = 0;

  zeroriscy_fetch_req_ctrl #(.RESET_FETCH_ADDR(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        branch;
    logic [31:0] addr;
    logic        ready;
    logic        gnt;
    logic        rvalid;
    logic        expReq;
    logic [31:0] expIaddr;
    logic        expValid;
    logic [31:0] expFaddr;
    logic        expClear;
    logic        expBusy;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  vec_t  vecs[$];
  pend_t pendQ[$];

  function automatic vec_t mk(logic req, logic branch, logic [31:0] addr,
                              logic ready, logic gnt, logic rvalid,
                              logic expReq, logic [31:0] expIaddr,
                              logic expValid, logic [31:0] expFaddr,
                              logic expClear, logic expBusy);
    vec_t v;
    v.req = req; v.branch = branch; v.addr = addr; v.ready = ready;
    v.gnt = gnt; v.rvalid = rvalid; v.expReq = expReq; v.expIaddr = expIaddr;
    v.expValid = expValid; v.expFaddr = expFaddr; v.expClear = expClear;
    v.expBusy = expBusy;
    return v;
  endfunction

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs away from the rising edge, then let outputs settle.
  task automatic applyStimulus(input logic req, input logic branch,
                               input logic [31:0] addr, input logic ready,
                               input logic gnt, input logic rvalid,
                               input logic [31:0] rdata);
    @(negedge clk);
    req_i          = req;
    branch_i       = branch;
    addr_i         = addr;
    fifo_ready_i   = ready;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rvalid;
    instr_rdata_i  = rdata;
    #1;
  endtask

  initial begin
    logic [31:0] nextFetch;
    bit          prevReqNoGnt;
    logic        rReq, rBranch, rReady, rGnt, rRvalid, expValid;
    logic [31:0] rAddr, rData;
    pend_t       p;

    rst_n = 1'b0;
    req_i = 1'b0; branch_i = 1'b0; addr_i = '0; fifo_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    #2;
    checkOutput("rstReq",   instr_req_o,  32'd0);
    checkOutput("rstBusy",  busy_o,       32'd0);
    checkOutput("rstValid", fifo_valid_o, 32'd0);
    checkOutput("rstIaddr", instr_addr_o, 32'h0);
    checkOutput("rstFaddr", fifo_addr_o,  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // req branch addr ready gnt rvalid | req iaddr valid faddr clear busy
    vecs.push_back(mk(0,0,32'h0,        0,0,0, 0,32'h0,        0,32'h0,        0,0));
    vecs.push_back(mk(1,1,32'h80,       1,1,0, 1,32'h80,       0,32'h0,        1,0));
    vecs.push_back(mk(1,0,32'h0,        1,1,1, 1,32'h84,       1,32'h80,       0,1));
    vecs.push_back(mk(1,0,32'h0,        1,1,1, 1,32'h88,       1,32'h84,       0,1));
    vecs.push_back(mk(1,0,32'h0,        1,1,1, 1,32'h8C,       1,32'h88,       0,1));
    vecs.push_back(mk(1,1,32'h102,      1,0,0, 0,32'h100,      0,32'h8C,       1,1));
    vecs.push_back(mk(1,0,32'h0,        1,1,1, 1,32'h100,      0,32'h102,      0,1));
    vecs.push_back(mk(0,0,32'h0,        1,0,1, 0,32'h104,      1,32'h102,      0,1));
    vecs.push_back(mk(1,0,32'h0,        1,1,0, 1,32'h104,      0,32'h104,      0,0));
    vecs.push_back(mk(0,0,32'h0,        1,0,1, 0,32'h108,      1,32'h104,      0,1));
    vecs.push_back(mk(1,0,32'h0,        1,0,0, 1,32'h108,      0,32'h108,      0,0));
    vecs.push_back(mk(0,0,32'h0,        1,0,0, 1,32'h108,      0,32'h108,      0,1));
    vecs.push_back(mk(0,1,32'h200,      1,0,0, 1,32'h200,      0,32'h108,      1,1));
    vecs.push_back(mk(0,0,32'h0,        1,1,0, 1,32'h200,      0,32'h200,      0,1));
    vecs.push_back(mk(0,0,32'h0,        1,0,1, 0,32'h204,      1,32'h200,      0,1));
    vecs.push_back(mk(1,0,32'h0,        0,1,0, 0,32'h204,      0,32'h204,      0,0));
    vecs.push_back(mk(1,0,32'h0,        1,1,0, 1,32'h204,      0,32'h204,      0,0));
    vecs.push_back(mk(1,0,32'h0,        0,0,1, 0,32'h208,      1,32'h204,      0,1));
    vecs.push_back(mk(1,1,32'hFFFF_FFFC,1,1,0, 1,32'hFFFF_FFFC,0,32'h208,      1,0));
    vecs.push_back(mk(1,0,32'h0,        1,0,1, 1,32'h0,        1,32'hFFFF_FFFC,0,1));
    vecs.push_back(mk(0,0,32'h0,        1,1,0, 1,32'h0,        0,32'h0,        0,1));
    vecs.push_back(mk(0,0,32'h0,        1,0,1, 0,32'h4,        1,32'h0,        0,1));
    vecs.push_back(mk(1,0,32'h0,        1,1,0, 1,32'h4,        0,32'h4,        0,0));
    vecs.push_back(mk(0,1,32'h302,      1,1,1, 1,32'h300,      0,32'h4,        1,1));
    vecs.push_back(mk(0,0,32'h0,        1,0,1, 0,32'h304,      1,32'h302,      0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].branch, vecs[i].addr, vecs[i].ready,
                    vecs[i].gnt, vecs[i].rvalid, 32'hC0DE_0000 + 32'(i));
      checkOutput($sformatf("v%0d.req", i),   instr_req_o,  32'(vecs[i].expReq));
      checkOutput($sformatf("v%0d.iaddr", i), instr_addr_o, vecs[i].expIaddr);
      checkOutput($sformatf("v%0d.valid", i), fifo_valid_o, 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d.faddr", i), fifo_addr_o,  vecs[i].expFaddr);
      checkOutput($sformatf("v%0d.clear", i), fifo_clear_o, 32'(vecs[i].expClear));
      checkOutput($sformatf("v%0d.busy", i),  busy_o,       32'(vecs[i].expBusy));
      if (vecs[i].expValid)
        checkOutput($sformatf("v%0d.rdata", i), fifo_rdata_o, 32'hC0DE_0000 + 32'(i));
    end

    // Reset in the middle of a transaction, then a late response while idle.
    applyStimulus(1, 1, 32'h400, 1, 1, 0, 32'h0);
    checkOutput("midRstIssue", instr_req_o, 32'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("midRstBusyBefore", busy_o, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy",  busy_o,       32'd0);
    checkOutput("midRstIaddr", instr_addr_o, 32'h0);
    checkOutput("midRstFaddr", fifo_addr_o,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0, 1, 0, 1, 32'hDEAD_BEEF);
    checkOutput("lateRvalidValid", fifo_valid_o, 32'd0);
    checkOutput("lateRvalidReq",   instr_req_o,  32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
    checkOutput("lateRvalidBusy",  busy_o,       32'd0);

    // Randomized traffic against a scoreboard of outstanding requests.
    nextFetch    = 32'h0;
    prevReqNoGnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rReq    = ($urandom_range(0, 9) < 8);
      rReady  = ($urandom_range(0, 3) != 0);
      rBranch = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rAddr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rAddr = $urandom;
      rGnt    = $urandom_range(0, 1) == 1;
      rRvalid = (pendQ.size() != 0) && ($urandom_range(0, 1) == 1);
      rData   = $urandom;
      applyStimulus(rReq, rBranch, rAddr, rReady, rGnt, rRvalid, rData);

      checkOutput("rndClear", fifo_clear_o, 32'(rBranch));
      if (prevReqNoGnt) checkOutput("rndReqHeld", instr_req_o, 32'd1);

      expValid = 1'b0;
      if (rRvalid) begin
        p = pendQ.pop_front();
        expValid = !p.stale && !rBranch;
      end
      checkOutput("rndValid", fifo_valid_o, 32'(expValid));
      if (expValid && fifo_valid_o) begin
        checkOutput("rndFaddr", fifo_addr_o,  p.addr);
        checkOutput("rndRdata", fifo_rdata_o, rData);
      end

      if (rBranch) begin
        foreach (pendQ[k]) pendQ[k].stale = 1;
        nextFetch = rAddr & 32'hFFFF_FFFE;
      end

      if (pendQ.size() != 0)
        checkOutput("rndOneOutstanding", instr_req_o, 32'd0);
      else if ((rReq && rReady) || rBranch)
        checkOutput("rndIssue", instr_req_o, 32'd1);

      if (instr_req_o && rGnt) begin
        checkOutput("rndReqAddr", instr_addr_o, {nextFetch[31:2], 2'b00});
        pendQ.push_back('{addr: nextFetch, stale: 1'b0});
        nextFetch = {nextFetch[31:2], 2'b00} + 32'd4;
      end
      prevReqNoGnt = instr_req_o && !rGnt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
